// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage.
package if_stage_pkg;
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD} fetch_state_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between fetch stage and memory.
interface if_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush clears, load captures, stall holds, otherwise bubble.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output if_id_t      o_q
);
    if_id_t r_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= '{valid: 1'b0, instr: NOP_INSTR, pc: RESET_PC};
        else if (i_flush) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end
        else if (i_load) r_q <= '{valid: 1'b1, instr: i_instr, pc: i_pc};
        else if (!i_stall) r_q.valid <= 1'b0;
    assign o_q = r_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch stage holding the PC, one outstanding imem request, and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    if_stage_if.master  imem,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc
);
    fetch_state_t r_state, w_state_n;
    logic [31:0]  r_pc, w_pc_n, r_hold, w_hold_n, w_instr;
    logic         r_kill, w_kill_n, w_load, w_hs;
    if_id_t       w_if_id;
    assign imem.req_valid = (r_state == ISSUE) && !rst;
    assign imem.req_addr  = r_pc;
    assign w_hs           = imem.req_valid && imem.req_ready;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= ISSUE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_hold  <= NOP_INSTR;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_kill  <= w_kill_n;
            r_hold  <= w_hold_n;
        end
    // Flush reloads pc from every state; per-state logic only decides the fetch side-effects.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = flush ? next_pc : r_pc;
        w_kill_n  = r_kill;
        w_hold_n  = flush ? NOP_INSTR : r_hold;
        w_load    = 1'b0;
        w_instr   = r_hold;
        case (r_state)
            ISSUE: if (w_hs) begin
                w_state_n = WAIT;
                w_kill_n  = flush;
            end
            WAIT: if (imem.resp_valid) begin
                w_state_n = ISSUE;
                w_kill_n  = 1'b0;
                if (!r_kill && !flush) begin
                    if (stall) begin
                        w_state_n = HOLD;
                        w_hold_n  = imem.resp_data;
                    end else begin
                        w_load  = 1'b1;
                        w_instr = imem.resp_data;
                        w_pc_n  = next_pc;
                    end
                end
            end else if (flush) w_kill_n = 1'b1;
            HOLD: if (flush) w_state_n = ISSUE;
                else if (!stall) begin
                    w_state_n = ISSUE;
                    w_load    = 1'b1;
                    w_pc_n    = next_pc;
                end
            default: w_state_n = ISSUE;
        endcase
    end
    if_id_reg #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_stall (stall),
        .i_flush (flush),
        .i_instr (w_instr),
        .i_pc    (r_pc),
        .o_q     (w_if_id)
    );
    assign pc          = r_pc;
    assign if_id_valid = w_if_id.valid;
    assign if_id_instr = w_if_id.instr;
    assign if_id_pc    = w_if_id.pc;
    a_resp_in_wait: assert property (@(posedge clk) disable iff (rst) imem.resp_valid |-> r_state == WAIT);
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of reset, sequential fetch, backpressure, stall and flush.
module tb_if_stage;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_pc = 32'h0, next_pc, pc, if_id_instr, if_id_pc;
    logic        if_id_valid;
    int          n_tests = 0, n_fail = 0;
    int          cfg_rdly = 0, cfg_rdel = 1, ready_cnt = 0, resp_cnt = 0;
    logic        pending = 1'b0;
    logic [31:0] paddr = 32'h0;
    if_stage_if mem ();
    if_stage #(.RESET_PC(32'h40), .NOP_INSTR(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .pc          (pc),
        .imem        (mem),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc)
    );
    always #5 clk = ~clk;
    assign next_pc        = ovr_en ? ovr_pc : pc + 32'd1;
    assign mem.req_ready  = mem.req_valid && (ready_cnt >= cfg_rdly);
    assign mem.resp_valid = pending && (resp_cnt == 0);
    assign mem.resp_data  = {16'hC0DE, paddr[15:0]};
    always @(posedge clk or posedge rst)
        if (rst) begin
            pending   <= 1'b0;
            ready_cnt <= 0;
            resp_cnt  <= 0;
        end else begin
            if (mem.req_valid && mem.req_ready) begin
                ready_cnt <= 0;
                pending   <= 1'b1;
                resp_cnt  <= cfg_rdel - 1;
                paddr     <= mem.req_addr;
            end else if (mem.req_valid) ready_cnt <= ready_cnt + 1;
            if (pending) begin
                if (resp_cnt == 0) pending <= 1'b0;
                else resp_cnt <= resp_cnt - 1;
            end
        end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        // Reset, then reset again while a fetch is outstanding
        repeat (2) tick;
        check("rst_vld", {31'b0, mem.req_valid}, 32'd0);
        cfg_rdly = 0;
        cfg_rdel = 5;
        rst = 1'b0;
        #1;
        check("rel_vld", {31'b0, mem.req_valid}, 32'd1);
        tick;
        check("wait_vld", {31'b0, mem.req_valid}, 32'd0);
        tick;
        rst = 1'b1;
        cfg_rdly = 100;
        #1;
        check("rst2_pc", pc, 32'h40);
        check("rst2_ifv", {31'b0, if_id_valid}, 32'd0);
        check("rst2_ipc", if_id_pc, 32'h40);
        check("rst2_vld", {31'b0, mem.req_valid}, 32'd0);
        tick;
        check("rst3_vld", {31'b0, mem.req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel2_vld", {31'b0, mem.req_valid}, 32'd1);
        check("rel2_addr", mem.req_addr, 32'h40);
        // Flush in ISSUE without handshake retargets to 0
        ovr_en = 1'b1;
        ovr_pc = 32'h0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        ovr_en = 1'b0;
        check("fi_pc", pc, 32'h0);
        check("fi_addr", mem.req_addr, 32'h0);
        check("fi_vld", {31'b0, mem.req_valid}, 32'd1);
        // Sequential fetch, one instruction per two cycles
        cfg_rdly = 0;
        cfg_rdel = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("seq_wvld", {31'b0, mem.req_valid}, 32'd0);
            if (i > 0) check("seq_bub", {31'b0, if_id_valid}, 32'd0);
            tick;
            check("seq_ifv", {31'b0, if_id_valid}, 32'd1);
            check("seq_ipc", if_id_pc, i);
            check("seq_ins", if_id_instr, {16'hC0DE, 16'(i)});
            check("seq_pc", pc, i + 1);
        end
        // Backpressure: ready low 3 cycles, response 4 cycles after handshake
        cfg_rdly = 3;
        cfg_rdel = 4;
        for (int i = 0; i < 4; i++) begin
            check("bp_vld", {31'b0, mem.req_valid}, 32'd1);
            check("bp_addr", mem.req_addr, 32'h4);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_wpc", pc, 32'h4);
            check("bp_wifv", {31'b0, if_id_valid}, 32'd0);
            tick;
        end
        tick;
        check("bp_ifv", {31'b0, if_id_valid}, 32'd1);
        check("bp_ins", if_id_instr, 32'hC0DE0004);
        check("bp_pc", pc, 32'h5);
        tick;
        check("bp_once", {31'b0, if_id_valid}, 32'd0);
        check("bp_pc2", pc, 32'h5);
        // Stall for 5 cycles while the response arrives
        cfg_rdly = 0;
        cfg_rdel = 1;
        tick;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("st_pc", pc, 32'h5);
            check("st_vld", {31'b0, mem.req_valid}, 32'd0);
            check("st_ipc", if_id_pc, 32'h4);
            check("st_ifv", {31'b0, if_id_valid}, 32'd0);
        end
        stall = 1'b0;
        tick;
        check("st_rel_ifv", {31'b0, if_id_valid}, 32'd1);
        check("st_rel_ins", if_id_instr, 32'hC0DE0005);
        check("st_rel_ipc", if_id_pc, 32'h5);
        check("st_rel_pc", pc, 32'h6);
        // Flush in WAIT before the response
        cfg_rdel = 3;
        tick;
        flush = 1'b1;
        ovr_en = 1'b1;
        ovr_pc = 32'h100;
        tick;
        flush = 1'b0;
        ovr_en = 1'b0;
        check("fw_pc", pc, 32'h100);
        check("fw_ifv", {31'b0, if_id_valid}, 32'd0);
        check("fw_ins", if_id_instr, 32'h0);
        tick;
        check("fw_wvld", {31'b0, mem.req_valid}, 32'd0);
        tick;
        check("fw_vld", {31'b0, mem.req_valid}, 32'd1);
        check("fw_addr", mem.req_addr, 32'h100);
        check("fw_drop", {31'b0, if_id_valid}, 32'd0);
        check("fw_drop_ins", if_id_instr, 32'h0);
        // Flush and stall together in HOLD
        cfg_rdel = 1;
        tick;
        stall = 1'b1;
        tick;
        tick;
        check("fh_hold", {31'b0, mem.req_valid}, 32'd0);
        flush = 1'b1;
        ovr_en = 1'b1;
        ovr_pc = 32'h200;
        cfg_rdly = 100;
        tick;
        flush = 1'b0;
        ovr_en = 1'b0;
        check("fh_pc", pc, 32'h200);
        check("fh_vld", {31'b0, mem.req_valid}, 32'd1);
        check("fh_addr", mem.req_addr, 32'h200);
        check("fh_ifv", {31'b0, if_id_valid}, 32'd0);
        stall = 1'b0;
        tick;
        check("fh_noleak", {31'b0, if_id_valid}, 32'd0);
        check("fh_pc2", pc, 32'h200);
        cfg_rdly = 0;
        tick;
        tick;
        check("fh_ifv2", {31'b0, if_id_valid}, 32'd1);
        check("fh_ins2", if_id_instr, 32'hC0DE0200);
        check("fh_pc3", pc, 32'h201);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
